urna_report_tx: RTL and testbench

//  Reads the ballot box's final counters and sends them off-chip as a serial report (boletim de urna).

---
 rtl/urna_pkg.sv | 16 +
 rtl/urna_report_tx_if.sv | 14 +
 rtl/uart_tx_byte.sv | 63 ++++++
 rtl/urna_report_tx.sv | 80 ++++++++
 tb/tb_urna_report_tx.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/urna_pkg.sv
// Shared types and constants for the Urna voting core and its report transmitter.
package urna_pkg;
  localparam int         COUNT_W     = 8;
  localparam logic [7:0] URNA_HDR    = 8'hB5;
  localparam int         FRAME_BYTES = 5;

  // Serial line states; DONE is only meaningful at the report level.
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} tx_state_t;

  // Report sequencer states.
  typedef enum logic [1:0] {RPT_IDLE, RPT_SEND, RPT_DONE} rpt_state_t;

  function automatic logic [7:0] frame_chk(input logic [7:0] hdr, c1, c2, nul);
    return hdr ^ c1 ^ c2 ^ nul;
  endfunction
endpackage

// File: rtl/urna_report_tx_if.sv
// Bundle between the voting core (master) and the report transmitter (slave).
interface urna_report_tx_if;
  import urna_pkg::*;
  logic               finish;
  logic [COUNT_W-1:0] TotalC1;
  logic [COUNT_W-1:0] TotalC2;
  logic [COUNT_W-1:0] TotalNull;
  logic               tx;
  logic               busy;
  logic               done;

  modport master (output finish, TotalC1, TotalC2, TotalNull, input tx, busy, done);
  modport slave  (input finish, TotalC1, TotalC2, TotalNull, output tx, busy, done);
endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer; ready also asserts on the last STOP cycle so bytes chain without gaps.
module uart_tx_byte
  import urna_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] tx_byte,
  output logic       tx,
  output logic       ready
);
  localparam int             BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_t     state, nxt;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          baud_end;

  assign baud_end = (baud_cnt == BAUD_LAST);
  assign ready    = (state == IDLE) || (state == STOP && baud_end);

  always_comb begin
    nxt = state;
    tx  = 1'b1;
    case (state)
      IDLE:  if (load) nxt = START;
      START: begin
        tx = 1'b0;
        if (baud_end) nxt = DATA;
      end
      DATA: begin
        tx = shreg[0];
        if (baud_end && bit_cnt == 3'd7) nxt = STOP;
      end
      STOP:  if (baud_end) nxt = load ? START : IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      state    <= nxt;
      baud_cnt <= (state == IDLE || baud_end) ? '0 : baud_cnt + 1'b1;
      if (load && ready)
        shreg <= tx_byte;
      else if (state == DATA && baud_end)
        shreg <= shreg >> 1;
      if (state == START)
        bit_cnt <= '0;
      else if (state == DATA && baud_end)
        bit_cnt <= bit_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/urna_report_tx.sv
// Snapshots the ballot totals on a finish rise and sends HEADER, C1, C2, Null, checksum over UART.
module urna_report_tx
  import urna_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 4,
  parameter logic [7:0] HEADER       = URNA_HDR
) (
  input logic             clk,
  input logic             rst_n,
  urna_report_tx_if.slave bus
);
  localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES);

  rpt_state_t                  state, nxt;
  logic                        finish_q;
  logic                        trigger;
  logic [FRAME_BYTES-1:0][7:0] frame_q;
  logic [2:0]                  byte_idx;
  logic                        load;
  logic [7:0]                  cur_byte;
  logic                        u_ready;
  logic                        u_tx;

  assign trigger = bus.finish & ~finish_q;

  // Byte 0 goes straight from HEADER because the snapshot lands on the same edge.
  always_comb begin
    nxt      = state;
    load     = 1'b0;
    cur_byte = HEADER;
    case (state)
      RPT_IDLE: if (trigger) begin
        nxt  = RPT_SEND;
        load = 1'b1;
      end
      RPT_SEND: if (u_ready) begin
        if (byte_idx == LAST_IDX) begin
          nxt = RPT_DONE;
        end else begin
          load     = 1'b1;
          cur_byte = frame_q[byte_idx];
        end
      end
      RPT_DONE: if (!bus.finish) nxt = RPT_IDLE;
      default:  nxt = RPT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= RPT_IDLE;
      finish_q <= 1'b0;
      frame_q  <= '0;
      byte_idx <= '0;
    end else begin
      state    <= nxt;
      finish_q <= bus.finish;
      if (state == RPT_IDLE && trigger) begin
        frame_q  <= {frame_chk(HEADER, bus.TotalC1, bus.TotalC2, bus.TotalNull),
                     bus.TotalNull, bus.TotalC2, bus.TotalC1, HEADER};
        byte_idx <= 3'd1;
      end else if (load) begin
        byte_idx <= byte_idx + 1'b1;
      end
    end
  end

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .tx_byte (cur_byte),
    .tx      (u_tx),
    .ready   (u_ready)
  );

  assign bus.tx   = u_tx;
  assign bus.busy = (state == RPT_SEND);
  assign bus.done = (state == RPT_DONE);
endmodule

// File: tb/tb_urna_report_tx.sv
// Directed bench for urna_report_tx: decodes the serial line and checks frames, busy length and done.
module tb_urna_report_tx;
  import urna_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  urna_report_tx_if bus();

  urna_report_tx #(.CLKS_PER_BIT(4), .HEADER(8'hB5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;
  int busy_cycles = 0;
  int frames = 0;
  logic busy_d = 1'b0;

  always @(negedge clk) begin
    if (bus.busy === 1'b1) busy_cycles++;
    if (bus.busy === 1'b1 && busy_d !== 1'b1) frames++;
    busy_d = bus.busy;
  end

  typedef struct {
    logic [7:0]       c1, c2, nul;
    bit               mutate;
    logic [4:0][7:0]  exp;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // UART model: waits (bounded) for the start bit, then samples mid-bit for 5 back-to-back bytes.
  task automatic recv_frame(output logic [4:0][7:0] got, output bit ok, output int lat);
    bit seen = 0;
    got = '0;
    lat = 0;
    for (int w = 0; w < 20 && !seen; w++) begin
      @(negedge clk);
      if (bus.tx === 1'b0) begin
        seen = 1;
        lat = w + 1;
      end
    end
    ok = seen;
    if (!seen) return;
    repeat (2) @(negedge clk);
    for (int b = 0; b < 5; b++) begin
      if (bus.tx !== 1'b0) ok = 0;
      for (int i = 0; i < 8; i++) begin
        repeat (4) @(negedge clk);
        got[b][i] = bus.tx;
      end
      repeat (4) @(negedge clk);
      if (bus.tx !== 1'b1) ok = 0;
      if (b < 4) repeat (4) @(negedge clk);
    end
  endtask

  task automatic check_bytes(input string name, input logic [4:0][7:0] got,
                             input logic [4:0][7:0] exp);
    for (int b = 0; b < 5; b++)
      check($sformatf("%s byte%0d", name, b), 32'(got[b]), 32'(exp[b]));
  endtask

  task automatic set_totals(input logic [7:0] c1, c2, nul);
    bus.TotalC1   = c1;
    bus.TotalC2   = c2;
    bus.TotalNull = nul;
  endtask

  logic [4:0][7:0] got;
  bit              ok;
  int              lat;
  int              b0, f0, done_seen, busy_seen;

  initial begin
    vecs[0] = '{c1: 8'h02, c2: 8'h01, nul: 8'h02, mutate: 1'b0,
                exp: {8'hB4, 8'h02, 8'h01, 8'h02, 8'hB5}};
    vecs[1] = '{c1: 8'hFF, c2: 8'hFF, nul: 8'hFF, mutate: 1'b0,
                exp: {8'h4A, 8'hFF, 8'hFF, 8'hFF, 8'hB5}};
    vecs[2] = '{c1: 8'h12, c2: 8'h34, nul: 8'h56, mutate: 1'b1,
                exp: {8'hC5, 8'h56, 8'h34, 8'h12, 8'hB5}};
    vecs[3] = '{c1: 8'h00, c2: 8'h00, nul: 8'h00, mutate: 1'b0,
                exp: {8'hB5, 8'h00, 8'h00, 8'h00, 8'hB5}};

    // Reset with finish already high: nothing may go out.
    bus.finish = 1'b1;
    set_totals(8'h11, 8'h22, 8'h33);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset tx", 32'(bus.tx), 32'd1);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset frames", 32'(frames), 32'd0);
    bus.finish = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post-reset frames", 32'(frames), 32'd0);

    for (int v = 0; v < 4; v++) begin
      set_totals(vecs[v].c1, vecs[v].c2, vecs[v].nul);
      b0 = busy_cycles;
      bus.finish = 1'b1;
      fork
        recv_frame(got, ok, lat);
        if (vecs[v].mutate) begin
          repeat (100) @(negedge clk);
          set_totals(8'h00, 8'h00, 8'h00);
        end
      join
      check($sformatf("v%0d framing", v), 32'(ok), 32'd1);
      check($sformatf("v%0d tx latency", v), 32'(lat), 32'd1);
      check_bytes($sformatf("v%0d", v), got, vecs[v].exp);
      repeat (3) @(negedge clk);
      check($sformatf("v%0d busy cycles", v), 32'(busy_cycles - b0), 32'd200);
      check($sformatf("v%0d done held", v), 32'(bus.done), 32'd1);
      check($sformatf("v%0d busy after", v), 32'(bus.busy), 32'd0);
      bus.finish = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d done cleared", v), 32'(bus.done), 32'd0);
      repeat (3) @(negedge clk);
    end

    // Long finish level: one frame only, then a fresh rise gives a second one.
    set_totals(8'h07, 8'h08, 8'h09);
    f0 = frames;
    bus.finish = 1'b1;
    recv_frame(got, ok, lat);
    check("hold framing", 32'(ok), 32'd1);
    check_bytes("hold", got, {8'hB3, 8'h09, 8'h08, 8'h07, 8'hB5});
    repeat (300) @(negedge clk);
    check("hold single frame", 32'(frames - f0), 32'd1);
    check("hold done", 32'(bus.done), 32'd1);
    bus.finish = 1'b0;
    repeat (2) @(negedge clk);
    bus.finish = 1'b1;
    recv_frame(got, ok, lat);
    check("refire framing", 32'(ok), 32'd1);
    check_bytes("refire", got, {8'hB3, 8'h09, 8'h08, 8'h07, 8'hB5});
    repeat (3) @(negedge clk);
    check("refire frame count", 32'(frames - f0), 32'd2);
    bus.finish = 1'b0;
    repeat (3) @(negedge clk);

    // Reset in the middle of byte 2 (C2=0, so the line is low there).
    set_totals(8'h01, 8'h00, 8'h03);
    bus.finish = 1'b1;
    repeat (90) @(negedge clk);
    check("pre-abort tx low", 32'(bus.tx), 32'd0);
    rst_n = 1'b0;
    bus.finish = 1'b0;
    @(negedge clk);
    check("abort tx", 32'(bus.tx), 32'd1);
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    busy_seen = 0;
    repeat (250) begin
      @(negedge clk);
      if (bus.done !== 1'b0) done_seen++;
      if (bus.busy !== 1'b0) busy_seen++;
      if (bus.tx !== 1'b1) busy_seen++;
    end
    check("abort no done", 32'(done_seen), 32'd0);
    check("abort line idle", 32'(busy_seen), 32'd0);
    bus.finish = 1'b1;
    recv_frame(got, ok, lat);
    check("after-abort framing", 32'(ok), 32'd1);
    check_bytes("after-abort", got, {8'hB7, 8'h03, 8'h00, 8'h01, 8'hB5});
    repeat (3) @(negedge clk);
    check("after-abort done", 32'(bus.done), 32'd1);
    bus.finish = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
